mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; widths fixed: word data 32, word address 30, register address 5, ctrl op 2, mem op 2, exception code 3.
REQ-002 Encodings: mem op NOP=0, LDW=1, STW=2; exception NO_EXP=0, MISS_ALIGN=4; ctrl op NOP=0; BusRW READ=1, WRITE=0.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  stage clock.
REQ-005 reset_  in  1  async active-low reset.
REQ-006 EXPC  in  30  EX-stage word PC.
REQ-007 EXEn  in  1  EX-stage valid.
REQ-008 EXBrFlag  in  1  EX instruction is in a branch delay slot.
REQ-009 EXMemOp  in  2  memory operation.
REQ-010 EXMemWrData  in  32  store data.
REQ-011 EXCtrlOp  in  2  control op, passed through.
REQ-012 EXDstAddr  in  5  destination register.
REQ-013 EXGPRWE_  in  1  GPR write enable, active-low.
REQ-014 EXExpCode  in  3  upstream exception code.
REQ-015 EXOut  in  32  ALU result / byte address.
REQ-016 Stall, Flush  in  1 each  from ctrl (MemStall, MemFlush).
REQ-017 MemBusy  out  1  stage cannot complete this cycle.
REQ-018 BusReq_  out  1  bus request, active-low.
REQ-019 BusGrnt_  in  1  bus grant, active-low.
REQ-020 BusAs_  out  1  address strobe, active-low.
REQ-021 BusAddr  out  30  word address; BusRW out 1; BusWrData out 32.
REQ-022 BusRdData  in  32; BusRdy_  in  1  transfer complete, active-low.
REQ-023 MemPC out 30, MemEn out 1, MemBrFlag out 1, MemCtrlOp out 2, MemDstAddr out 5, MemGPRWE_ out 1, MemExpCode out 3, MemOut out 32  registered pipeline outputs to ctrl and writeback.

Function
REQ-024 Misalign: EXEn=1, EXMemOp LDW/STW, EXOut[1:0]!=0 -> no bus access, MemExpCode=MISS_ALIGN, MemGPRWE_=1.
REQ-025 Access needed: EXEn=1, EXExpCode=NO_EXP, EXMemOp LDW/STW, aligned.
REQ-026 EXExpCode!=NO_EXP passes through unchanged; no bus access; misalign check skipped.
REQ-027 FSM states IDLE, REQ, ACCESS, DONE; reset state IDLE.
REQ-028 IDLE: access needed and Flush=0 -> REQ, MemBusy=1; access needed and Flush=1 -> stay IDLE, MemBusy=0.
REQ-029 REQ: BusReq_=0, MemBusy=1; BusGrnt_=0 -> ACCESS.
REQ-030 ACCESS: BusReq_=0, BusAs_=0, BusAddr=EXOut[31:2], BusRW=READ for LDW else WRITE, BusWrData=EXMemWrData; MemBusy=1.
REQ-031 ACCESS with BusRdy_=0: capture BusRdData into read buffer, -> DONE.
REQ-032 DONE: bus idle, MemBusy=0; Stall=0 -> IDLE; Stall=1 -> hold DONE, no re-issue.
REQ-033 Outside ACCESS: BusAs_=1, BusAddr=0, BusRW=READ, BusWrData=0; BusReq_=1 outside REQ/ACCESS.
REQ-034 Transaction started (REQ/ACCESS) always completes regardless of Flush; result dropped by pipeline-register rule.
REQ-035 Pipeline register update each clock: Stall=1 -> hold; else Flush=1 -> bubble; else load.
REQ-036 Bubble: MemEn=0, MemExpCode=NO_EXP, MemCtrlOp=NOP, MemGPRWE_=1, MemPC/MemBrFlag/MemDstAddr/MemOut=0.
REQ-037 Load: MemPC/MemEn/MemBrFlag/MemCtrlOp/MemDstAddr/MemGPRWE_ from EX (subject to REQ-024); MemOut=read buffer for LDW, else EXOut.
REQ-038 Latency with immediate grant and ready: LDW busy 3 cycles, result registered at end of 4th cycle; non-memory ops 1 cycle, no busy.

Reset
REQ-039 reset_=0 immediately: FSM IDLE, all bus strobes deasserted (1), BusAddr/BusWrData=0, BusRW=READ, read buffer=0, pipeline outputs = bubble values, MemBusy=0 if no access needed.
REQ-040 Reset mid-transaction aborts without waiting for BusRdy_.

Verification
REQ-041 LDW EXOut=0x100, grant/rdy immediate, BusRdData=0xDEADBEEF -> BusAddr=0x40 in ACCESS, MemBusy 3 cycles, MemOut=0xDEADBEEF.
REQ-042 STW EXOut=0x203 -> no BusReq_, MemExpCode=4, MemGPRWE_=1, MemBusy=0.
REQ-043 STW EXOut=0x8, data 0x12345678, BusRdy_ delayed 5 cycles -> BusRW=0, BusWrData=0x12345678 held, MemBusy stays 1 until rdy.
REQ-044 Flush=1 during ACCESS -> transfer completes, next load gives MemEn=0; Flush=1 in IDLE -> no BusReq_.
REQ-045 External Stall=1 in DONE 3 cycles -> no second bus request, outputs held, then single load.
REQ-046 reset_ low during ACCESS -> BusAs_/BusReq_=1 same cycle, MemEn=0, FSM IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// Memory access stage: runs one bus transaction per aligned LDW/STW.
// It also holds the MEM pipeline register that feeds ctrl and writeback.
module mem_stage (
    input  logic        clk,
    input  logic        reset_,
    input  logic [29:0] EXPC,
    input  logic        EXEn,
    input  logic        EXBrFlag,
    input  logic [1:0]  EXMemOp,
    input  logic [31:0] EXMemWrData,
    input  logic [1:0]  EXCtrlOp,
    input  logic [4:0]  EXDstAddr,
    input  logic        EXGPRWE_,
    input  logic [2:0]  EXExpCode,
    input  logic [31:0] EXOut,
    input  logic        Stall,
    input  logic        Flush,
    output logic        MemBusy,
    output logic        BusReq_,
    input  logic        BusGrnt_,
    output logic        BusAs_,
    output logic [29:0] BusAddr,
    output logic        BusRW,
    output logic [31:0] BusWrData,
    input  logic [31:0] BusRdData,
    input  logic        BusRdy_,
    output logic [29:0] MemPC,
    output logic        MemEn,
    output logic        MemBrFlag,
    output logic [1:0]  MemCtrlOp,
    output logic [4:0]  MemDstAddr,
    output logic        MemGPRWE_,
    output logic [2:0]  MemExpCode,
    output logic [31:0] MemOut
);

    localparam logic [1:0] MEM_LDW        = 2'd1;
    localparam logic [1:0] MEM_STW        = 2'd2;
    localparam logic [2:0] EXP_NONE       = 3'd0;
    localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;
    localparam logic [1:0] CTRL_NOP       = 2'd0;
    localparam logic       BUS_READ       = 1'b1;
    localparam logic       BUS_WRITE      = 1'b0;

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, DONE} state_t;

    state_t      state;
    logic [31:0] rd_buf;
    logic        is_mem_op;
    logic        is_aligned;
    logic        miss_align;
    logic        access_needed;

    // An upstream exception suppresses both the alignment check and the access.
    assign is_mem_op     = (EXMemOp == MEM_LDW) || (EXMemOp == MEM_STW);
    assign is_aligned    = (EXOut[1:0] == 2'b00);
    assign miss_align    = EXEn && (EXExpCode == EXP_NONE) && is_mem_op && !is_aligned;
    assign access_needed = EXEn && (EXExpCode == EXP_NONE) && is_mem_op && is_aligned;

    always_comb begin
        MemBusy = 1'b0;
        case (state)
            IDLE:        MemBusy = access_needed && !Flush;
            REQ, ACCESS: MemBusy = 1'b1;
            default:     MemBusy = 1'b0;
        endcase
    end

    // Bus strobes are registered from the transition being taken, so each state's outputs appear with it.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            BusReq_   <= 1'b1;
            BusAs_    <= 1'b1;
            BusAddr   <= 30'd0;
            BusRW     <= BUS_READ;
            BusWrData <= 32'd0;
            rd_buf    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (access_needed && !Flush) begin
                        state   <= REQ;
                        BusReq_ <= 1'b0;
                    end
                end
                REQ: begin
                    if (!BusGrnt_) begin
                        state     <= ACCESS;
                        BusAs_    <= 1'b0;
                        BusAddr   <= EXOut[31:2];
                        BusRW     <= (EXMemOp == MEM_LDW) ? BUS_READ : BUS_WRITE;
                        BusWrData <= EXMemWrData;
                    end
                end
                ACCESS: begin
                    // A started transfer always runs to BusRdy_, even under Flush.
                    if (!BusRdy_) begin
                        state     <= DONE;
                        rd_buf    <= BusRdData;
                        BusReq_   <= 1'b1;
                        BusAs_    <= 1'b1;
                        BusAddr   <= 30'd0;
                        BusRW     <= BUS_READ;
                        BusWrData <= 32'd0;
                    end
                end
                DONE: begin
                    if (!Stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            MemPC      <= 30'd0;
            MemEn      <= 1'b0;
            MemBrFlag  <= 1'b0;
            MemCtrlOp  <= CTRL_NOP;
            MemDstAddr <= 5'd0;
            MemGPRWE_  <= 1'b1;
            MemExpCode <= EXP_NONE;
            MemOut     <= 32'd0;
        end else if (!Stall) begin
            if (Flush) begin
                MemPC      <= 30'd0;
                MemEn      <= 1'b0;
                MemBrFlag  <= 1'b0;
                MemCtrlOp  <= CTRL_NOP;
                MemDstAddr <= 5'd0;
                MemGPRWE_  <= 1'b1;
                MemExpCode <= EXP_NONE;
                MemOut     <= 32'd0;
            end else begin
                MemPC      <= EXPC;
                MemEn      <= EXEn;
                MemBrFlag  <= EXBrFlag;
                MemCtrlOp  <= EXCtrlOp;
                MemDstAddr <= EXDstAddr;
                MemGPRWE_  <= miss_align ? 1'b1 : EXGPRWE_;
                MemExpCode <= miss_align ? EXP_MISS_ALIGN : EXExpCode;
                MemOut     <= (EXMemOp == MEM_LDW) ? rd_buf : EXOut;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a vector table for single-cycle ops and hand sequences for bus transactions.
// The ctrl stall is modelled as MemBusy OR an external stall request.
module tb_mem_stage;

    typedef struct packed {
        logic        en;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] out;
        logic [29:0] pc;
    } pipe_t;

    typedef struct packed {
        logic        en;
        logic        br;
        logic [1:0]  memop;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        we_;
        logic [2:0]  exp;
        logic [31:0] exout;
        logic [29:0] pc;
        logic [31:0] wrdata;
        logic        flush;
    } in_t;

    typedef struct {
        in_t   stim;
        pipe_t want;
    } vec_t;

    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] LDW = 2'd1;
    localparam logic [1:0] STW = 2'd2;

    logic        clk;
    logic        reset_;
    logic [29:0] EXPC;
    logic        EXEn;
    logic        EXBrFlag;
    logic [1:0]  EXMemOp;
    logic [31:0] EXMemWrData;
    logic [1:0]  EXCtrlOp;
    logic [4:0]  EXDstAddr;
    logic        EXGPRWE_;
    logic [2:0]  EXExpCode;
    logic [31:0] EXOut;
    logic        Stall;
    logic        Flush;
    logic        MemBusy;
    logic        BusReq_;
    logic        BusGrnt_;
    logic        BusAs_;
    logic [29:0] BusAddr;
    logic        BusRW;
    logic [31:0] BusWrData;
    logic [31:0] BusRdData;
    logic        BusRdy_;
    logic [29:0] MemPC;
    logic        MemEn;
    logic        MemBrFlag;
    logic [1:0]  MemCtrlOp;
    logic [4:0]  MemDstAddr;
    logic        MemGPRWE_;
    logic [2:0]  MemExpCode;
    logic [31:0] MemOut;

    logic  ext_stall;
    int    n_checks;
    int    n_fail;
    pipe_t exp_q[$];
    vec_t  vecs[8];
    in_t   idle;
    pipe_t bubble;
    pipe_t held;

    assign Stall = MemBusy | ext_stall;

    mem_stage dut (
        .clk(clk), .reset_(reset_),
        .EXPC(EXPC), .EXEn(EXEn), .EXBrFlag(EXBrFlag), .EXMemOp(EXMemOp),
        .EXMemWrData(EXMemWrData), .EXCtrlOp(EXCtrlOp), .EXDstAddr(EXDstAddr),
        .EXGPRWE_(EXGPRWE_), .EXExpCode(EXExpCode), .EXOut(EXOut),
        .Stall(Stall), .Flush(Flush), .MemBusy(MemBusy),
        .BusReq_(BusReq_), .BusGrnt_(BusGrnt_), .BusAs_(BusAs_), .BusAddr(BusAddr),
        .BusRW(BusRW), .BusWrData(BusWrData), .BusRdData(BusRdData), .BusRdy_(BusRdy_),
        .MemPC(MemPC), .MemEn(MemEn), .MemBrFlag(MemBrFlag), .MemCtrlOp(MemCtrlOp),
        .MemDstAddr(MemDstAddr), .MemGPRWE_(MemGPRWE_), .MemExpCode(MemExpCode), .MemOut(MemOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic in_t mkIn(input logic en, input logic br, input logic [1:0] memop,
                                 input logic [1:0] ctrl, input logic [4:0] dst, input logic we_,
                                 input logic [2:0] exp, input logic [31:0] exout,
                                 input logic [29:0] pc, input logic [31:0] wrdata, input logic flush);
        in_t s;
        s.en = en; s.br = br; s.memop = memop; s.ctrl = ctrl; s.dst = dst; s.we_ = we_;
        s.exp = exp; s.exout = exout; s.pc = pc; s.wrdata = wrdata; s.flush = flush;
        return s;
    endfunction

    function automatic pipe_t mkPipe(input logic en, input logic br, input logic [1:0] ctrl,
                                     input logic [4:0] dst, input logic we_, input logic [2:0] exp,
                                     input logic [31:0] out, input logic [29:0] pc);
        pipe_t p;
        p.en = en; p.br = br; p.ctrl = ctrl; p.dst = dst; p.we_ = we_;
        p.exp = exp; p.out = out; p.pc = pc;
        return p;
    endfunction

    function automatic pipe_t actualPipe();
        return mkPipe(MemEn, MemBrFlag, MemCtrlOp, MemDstAddr, MemGPRWE_, MemExpCode, MemOut, MemPC);
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveEx(input in_t s);
        EXEn = s.en; EXBrFlag = s.br; EXMemOp = s.memop; EXCtrlOp = s.ctrl;
        EXDstAddr = s.dst; EXGPRWE_ = s.we_; EXExpCode = s.exp; EXOut = s.exout;
        EXPC = s.pc; EXMemWrData = s.wrdata; Flush = s.flush;
    endtask

    task automatic applyStimulus(input in_t s, input pipe_t want);
        driveEx(s);
        exp_q.push_back(want);
    endtask

    task automatic checkOutput(input string name);
        pipe_t want;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, got %0h", name, actualPipe());
        end else begin
            want = exp_q.pop_front();
            chk(name, 96'(actualPipe()), 96'(want));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        ext_stall = 1'b0;
        BusGrnt_  = 1'b0;
        BusRdy_   = 1'b0;
        BusRdData = 32'd0;
        idle   = mkIn(1'b0, 1'b0, NOP, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0, 30'd0, 32'd0, 1'b0);
        bubble = mkPipe(1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0, 30'd0);

        vecs[0] = '{mkIn(1,0,NOP,2'd2,5'd5,0,3'd0,32'h11223344,30'h100,32'd0,0),
                    mkPipe(1,0,2'd2,5'd5,0,3'd0,32'h11223344,30'h100)};
        vecs[1] = '{mkIn(1,1,STW,2'd0,5'd0,1,3'd0,32'h203,30'h101,32'hAAAA,0),
                    mkPipe(1,1,2'd0,5'd0,1,3'd4,32'h203,30'h101)};
        vecs[2] = '{mkIn(1,0,STW,2'd1,5'd3,0,3'd0,32'h1,30'h102,32'd0,0),
                    mkPipe(1,0,2'd1,5'd3,1,3'd4,32'h1,30'h102)};
        vecs[3] = '{mkIn(1,0,STW,2'd0,5'd4,0,3'd2,32'h8,30'h103,32'd0,0),
                    mkPipe(1,0,2'd0,5'd4,0,3'd2,32'h8,30'h103)};
        vecs[4] = '{mkIn(1,1,STW,2'd3,5'd6,0,3'd1,32'h3,30'h104,32'd0,0),
                    mkPipe(1,1,2'd3,5'd6,0,3'd1,32'h3,30'h104)};
        vecs[5] = '{mkIn(0,0,STW,2'd0,5'd9,1,3'd0,32'h7,30'h105,32'd0,0),
                    mkPipe(0,0,2'd0,5'd9,1,3'd0,32'h7,30'h105)};
        vecs[6] = '{mkIn(1,0,NOP,2'd2,5'd5,0,3'd0,32'h55,30'h106,32'd0,1), bubble};
        vecs[7] = '{mkIn(1,0,STW,2'd0,5'd2,1,3'd0,32'h10,30'h107,32'h99,1), bubble};

        // Reset values
        driveEx(idle);
        reset_ = 1'b0;
        #12;
        chk("reset_pipe", 96'(actualPipe()), 96'(bubble));
        chk("reset_bus", {BusReq_, BusAs_, BusRW, BusAddr, BusWrData, MemBusy},
            {1'b1, 1'b1, 1'b1, 30'd0, 32'd0, 1'b0});
        reset_ = 1'b1;
        tick();

        // Single-cycle table: ALU ops, misalignment, exception pass-through, flush bubbles
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].stim, vecs[i].want);
            #1;
            chk($sformatf("vec%0d_busy", i), 96'(MemBusy), 96'(1'b0));
            chk($sformatf("vec%0d_busreq", i), 96'(BusReq_), 96'(1'b1));
            tick();
            checkOutput($sformatf("vec%0d_pipe", i));
        end
        driveEx(idle);
        tick();

        // LDW with immediate grant and ready
        BusGrnt_ = 1'b0; BusRdy_ = 1'b0; BusRdData = 32'hDEADBEEF;
        applyStimulus(mkIn(1,0,LDW,2'd0,5'd7,0,3'd0,32'h100,30'h200,32'd0,0),
                      mkPipe(1,0,2'd0,5'd7,0,3'd0,32'hDEADBEEF,30'h200));
        #1;
        chk("ldw_c1_busy", 96'(MemBusy), 96'(1'b1));
        tick();
        chk("ldw_req", {MemBusy, BusReq_, BusAs_}, {1'b1, 1'b0, 1'b1});
        tick();
        chk("ldw_access", {MemBusy, BusReq_, BusAs_, BusRW, BusAddr}, {1'b1, 1'b0, 1'b0, 1'b1, 30'h40});
        tick();
        chk("ldw_done", {MemBusy, BusReq_, BusAs_, BusAddr}, {1'b0, 1'b1, 1'b1, 30'h0});
        tick();
        checkOutput("ldw_result");
        driveEx(idle);
        tick();

        // STW with BusRdy_ held off for 5 cycles
        BusRdy_ = 1'b1;
        applyStimulus(mkIn(1,0,STW,2'd0,5'd0,1,3'd0,32'h8,30'h300,32'h12345678,0),
                      mkPipe(1,0,2'd0,5'd0,1,3'd0,32'h8,30'h300));
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stw_wait%0d", i), {MemBusy, BusAs_, BusRW, BusAddr, BusWrData},
                {1'b1, 1'b0, 1'b0, 30'h2, 32'h12345678});
            tick();
        end
        BusRdy_ = 1'b0;
        #1;
        chk("stw_rdy", {MemBusy, BusAs_, BusRW, BusWrData}, {1'b1, 1'b0, 1'b0, 32'h12345678});
        tick();
        chk("stw_done_busy", 96'(MemBusy), 96'(1'b0));
        tick();
        checkOutput("stw_result");
        driveEx(idle);
        tick();

        // Flush asserted during ACCESS: transfer completes, load becomes a bubble
        BusRdy_ = 1'b1; BusRdData = 32'hCAFEF00D;
        driveEx(mkIn(1,0,LDW,2'd0,5'd8,0,3'd0,32'h20,30'h400,32'd0,0));
        tick();
        tick();
        Flush = 1'b1;
        #1;
        chk("flush_access", {MemBusy, BusAs_, BusReq_}, {1'b1, 1'b0, 1'b0});
        BusRdy_ = 1'b0;
        tick();
        chk("flush_done", {MemBusy, BusAs_}, {1'b0, 1'b1});
        exp_q.push_back(bubble);
        tick();
        checkOutput("flush_result");
        chk("flush_idle", {MemBusy, BusReq_}, {1'b0, 1'b1});
        exp_q.push_back(bubble);
        tick();
        chk("flush_idle_noreq", 96'(BusReq_), 96'(1'b1));
        checkOutput("flush_idle_pipe");
        driveEx(idle);
        tick();

        // External stall while in DONE
        held = mkPipe(1,1,2'd1,5'd11,0,3'd0,32'h55AA,30'h3FF);
        applyStimulus(mkIn(1,1,NOP,2'd1,5'd11,0,3'd0,32'h55AA,30'h3FF,32'd0,0), held);
        tick();
        checkOutput("preload");
        BusRdData = 32'h0BADF00D;
        applyStimulus(mkIn(1,0,LDW,2'd0,5'd12,0,3'd0,32'h44,30'h500,32'd0,0),
                      mkPipe(1,0,2'd0,5'd12,0,3'd0,32'h0BADF00D,30'h500));
        tick();
        tick();
        tick();
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_bus", i), {MemBusy, BusReq_, BusAs_}, {1'b0, 1'b1, 1'b1});
            chk($sformatf("stall%0d_held", i), 96'(actualPipe()), 96'(held));
            tick();
        end
        ext_stall = 1'b0;
        tick();
        checkOutput("stall_result");
        driveEx(idle);
        tick();

        // Asynchronous reset in the middle of ACCESS
        BusRdy_ = 1'b1;
        driveEx(mkIn(1,0,LDW,2'd0,5'd13,0,3'd0,32'h100,30'h600,32'd0,0));
        tick();
        tick();
        chk("rst_pre_access", 96'(BusAs_), 96'(1'b0));
        reset_ = 1'b0;
        #1;
        chk("rst_bus", {BusAs_, BusReq_, BusAddr, MemEn}, {1'b1, 1'b1, 30'd0, 1'b0});
        driveEx(idle);
        #1;
        chk("rst_idle", 96'(MemBusy), 96'(1'b0));
        reset_ = 1'b1;
        tick();
        chk("rst_after", {BusReq_, BusAs_, MemBusy}, {1'b1, 1'b1, 1'b0});

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
